// File: rtl/qpu_moitf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qpu_moitf_pkg
// Description : Shared defaults and entry layout for the measurement OITF.
// Revision    : 1.0
// ============================================================================
package qpu_moitf_pkg;

    localparam int QPU_QUBIT_NUM        = 12;
    localparam int QPU_RFIDX_REAL_WIDTH = 5;
    localparam int MOITF_DEPTH_DEF      = 4;

    // Entry layout at the default qubit count and register width.
    typedef struct packed {
        logic [QPU_QUBIT_NUM-1:0]        ql;
        logic                            rdwen;
        logic [QPU_RFIDX_REAL_WIDTH-1:0] rdidx;
    } moitf_entry_t;

endpackage
`default_nettype wire

// File: rtl/qpu_moitf_entry.sv
`default_nettype none
// ============================================================================
// Module      : qpu_moitf_entry
// Description : One measurement OITF slot: valid flag, payload, hazard compare.
// Revision    : 1.0
// ============================================================================
module qpu_moitf_entry
    import qpu_moitf_pkg::*;
#(
    parameter int QUBIT_NUM = QPU_QUBIT_NUM,
    parameter int RFIDX_W   = QPU_RFIDX_REAL_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_set,
    input  logic                 i_clr,
    input  logic [QUBIT_NUM-1:0] i_ql,
    input  logic                 i_rdwen,
    input  logic [RFIDX_W-1:0]   i_rdidx,
    input  logic [QUBIT_NUM-1:0] i_chk_ql,
    input  logic                 i_chk_rs1en,
    input  logic                 i_chk_rs2en,
    input  logic                 i_chk_rdwen,
    input  logic [RFIDX_W-1:0]   i_chk_rs1idx,
    input  logic [RFIDX_W-1:0]   i_chk_rs2idx,
    input  logic [RFIDX_W-1:0]   i_chk_rdidx,
    output logic                 o_valid,
    output logic [QUBIT_NUM-1:0] o_ql,
    output logic                 o_rdwen,
    output logic [RFIDX_W-1:0]   o_rdidx,
    output logic                 o_match_ql,
    output logic                 o_match_rs1,
    output logic                 o_match_rs2,
    output logic                 o_match_rd
);

    logic                 r_valid;
    logic [QUBIT_NUM-1:0] r_ql;
    logic                 r_rdwen;
    logic [RFIDX_W-1:0]   r_rdidx;
    logic                 w_wr_live;

    // Clear wins so that a flush discards an allocation in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_set) begin
            r_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_set) begin
            r_ql    <= i_ql;
            r_rdwen <= i_rdwen;
            r_rdidx <= i_rdidx;
        end
    end

    assign w_wr_live   = r_valid & r_rdwen;
    assign o_valid     = r_valid;
    assign o_ql        = r_ql;
    assign o_rdwen     = r_rdwen;
    assign o_rdidx     = r_rdidx;
    assign o_match_ql  = r_valid & (|(r_ql & i_chk_ql));
    assign o_match_rs1 = i_chk_rs1en & w_wr_live & (r_rdidx == i_chk_rs1idx);
    assign o_match_rs2 = i_chk_rs2en & w_wr_live & (r_rdidx == i_chk_rs2idx);
    assign o_match_rd  = i_chk_rdwen & w_wr_live & (r_rdidx == i_chk_rdidx);

endmodule
`default_nettype wire

// File: rtl/qpu_exu_moitf_param.sv
`default_nettype none
// ============================================================================
// Module      : qpu_exu_moitf_param
// Description : Parametrised measurement outstanding-instruction FIFO.
// Revision    : 1.0
// ============================================================================
module qpu_exu_moitf_param
    import qpu_moitf_pkg::*;
#(
    parameter int DEPTH     = MOITF_DEPTH_DEF,
    parameter int QUBIT_NUM = QPU_QUBIT_NUM,
    parameter int RFIDX_W   = QPU_RFIDX_REAL_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_dis_ena,
    output logic                 o_dis_ready,
    input  logic [QUBIT_NUM-1:0] i_dis_ql,
    input  logic                 i_dis_rdwen,
    input  logic [RFIDX_W-1:0]   i_dis_rdidx,
    input  logic [QUBIT_NUM-1:0] i_chk_ql,
    input  logic                 i_chk_rs1en,
    input  logic                 i_chk_rs2en,
    input  logic                 i_chk_rdwen,
    input  logic [RFIDX_W-1:0]   i_chk_rs1idx,
    input  logic [RFIDX_W-1:0]   i_chk_rs2idx,
    input  logic [RFIDX_W-1:0]   i_chk_rdidx,
    output logic                 o_match_ql,
    output logic                 o_match_rs1,
    output logic                 o_match_rs2,
    output logic                 o_match_rd,
    input  logic                 i_ret_ena,
    output logic [QUBIT_NUM-1:0] o_ret_ql,
    output logic                 o_ret_rdwen,
    output logic [RFIDX_W-1:0]   o_ret_rdidx,
    input  logic                 i_flush,
    output logic                 o_empty,
    output logic                 o_full,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                 o_ret_err
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]       r_wr_ptr;
    logic [PTR_W:0]       r_rd_ptr;
    logic                 r_ret_err;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_alloc;
    logic                 w_retire;
    logic [PTR_W-1:0]     w_head;

    logic [DEPTH-1:0]     w_valid;
    logic [DEPTH-1:0]     w_m_ql;
    logic [DEPTH-1:0]     w_m_rs1;
    logic [DEPTH-1:0]     w_m_rs2;
    logic [DEPTH-1:0]     w_m_rd;
    logic [QUBIT_NUM-1:0] w_ent_ql    [DEPTH];
    logic                 w_ent_rdwen [DEPTH];
    logic [RFIDX_W-1:0]   w_ent_rdidx [DEPTH];

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]) &
                      (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]);
    assign w_alloc  = i_dis_ena & ~w_full;
    assign w_retire = i_ret_ena & ~w_empty;
    assign w_head   = r_rd_ptr[PTR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_ret_err <= 1'b0;
        end else begin
            if (i_ret_ena && w_empty) begin
                r_ret_err <= 1'b1;
            end
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_alloc)  r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_retire) r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            qpu_moitf_entry #(
                .QUBIT_NUM (QUBIT_NUM),
                .RFIDX_W   (RFIDX_W)
            ) u_entry (
                .clk          (clk),
                .rst_n        (rst_n),
                .i_set        (w_alloc & ~i_flush & (r_wr_ptr[PTR_W-1:0] == PTR_W'(gi))),
                .i_clr        (i_flush | (w_retire & (w_head == PTR_W'(gi)))),
                .i_ql         (i_dis_ql),
                .i_rdwen      (i_dis_rdwen),
                .i_rdidx      (i_dis_rdidx),
                .i_chk_ql     (i_chk_ql),
                .i_chk_rs1en  (i_chk_rs1en),
                .i_chk_rs2en  (i_chk_rs2en),
                .i_chk_rdwen  (i_chk_rdwen),
                .i_chk_rs1idx (i_chk_rs1idx),
                .i_chk_rs2idx (i_chk_rs2idx),
                .i_chk_rdidx  (i_chk_rdidx),
                .o_valid      (w_valid[gi]),
                .o_ql         (w_ent_ql[gi]),
                .o_rdwen      (w_ent_rdwen[gi]),
                .o_rdidx      (w_ent_rdidx[gi]),
                .o_match_ql   (w_m_ql[gi]),
                .o_match_rs1  (w_m_rs1[gi]),
                .o_match_rs2  (w_m_rs2[gi]),
                .o_match_rd   (w_m_rd[gi])
            );
        end
    endgenerate

    // Head fields read as zero whenever the head slot holds nothing.
    always_comb begin
        o_ret_ql    = '0;
        o_ret_rdwen = 1'b0;
        o_ret_rdidx = '0;
        if (w_valid[w_head]) begin
            o_ret_ql    = w_ent_ql[w_head];
            o_ret_rdwen = w_ent_rdwen[w_head];
            o_ret_rdidx = w_ent_rdidx[w_head];
        end
    end

    assign o_match_ql  = |w_m_ql;
    assign o_match_rs1 = |w_m_rs1;
    assign o_match_rs2 = |w_m_rs2;
    assign o_match_rd  = |w_m_rd;
    assign o_dis_ready = ~w_full;
    assign o_empty     = w_empty;
    assign o_full      = w_full;
    assign o_count     = r_wr_ptr - r_rd_ptr;
    assign o_ret_err   = r_ret_err;

endmodule
`default_nettype wire

// File: tb/tb_qpu_exu_moitf_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_qpu_exu_moitf_param
// Description : Directed self-checking bench for the measurement OITF.
// Revision    : 1.0
// ============================================================================
module tb_qpu_exu_moitf_param;
    import qpu_moitf_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dis_ena = 1'b0, dis_rdwen = 1'b0;
    logic [11:0] dis_ql = '0, chk_ql = '0;
    logic [4:0]  dis_rdidx = '0, chk_rs1idx = '0, chk_rs2idx = '0, chk_rdidx = '0;
    logic        chk_rs1en = 1'b0, chk_rs2en = 1'b0, chk_rdwen = 1'b0;
    logic        ret_ena = 1'b0, flush = 1'b0;
    logic        dis_ready, match_ql, match_rs1, match_rs2, match_rd;
    logic [11:0] ret_ql;
    logic        ret_rdwen, empty, full, ret_err;
    logic [4:0]  ret_rdidx;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    qpu_exu_moitf_param dut (
        .clk(clk), .rst_n(rst_n),
        .i_dis_ena(dis_ena), .o_dis_ready(dis_ready),
        .i_dis_ql(dis_ql), .i_dis_rdwen(dis_rdwen), .i_dis_rdidx(dis_rdidx),
        .i_chk_ql(chk_ql), .i_chk_rs1en(chk_rs1en), .i_chk_rs2en(chk_rs2en),
        .i_chk_rdwen(chk_rdwen), .i_chk_rs1idx(chk_rs1idx),
        .i_chk_rs2idx(chk_rs2idx), .i_chk_rdidx(chk_rdidx),
        .o_match_ql(match_ql), .o_match_rs1(match_rs1),
        .o_match_rs2(match_rs2), .o_match_rd(match_rd),
        .i_ret_ena(ret_ena), .o_ret_ql(ret_ql), .o_ret_rdwen(ret_rdwen),
        .o_ret_rdidx(ret_rdidx), .i_flush(flush),
        .o_empty(empty), .o_full(full), .o_count(count), .o_ret_err(ret_err)
    );

    typedef struct {
        logic [11:0] ql;
        logic        rs1en, rs2en, rden;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  exp;   // {ql, rs1, rs2, rd}
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [11:0] ql, input logic we, input logic [4:0] rd);
        dis_ena = 1'b1; dis_ql = ql; dis_rdwen = we; dis_rdidx = rd;
        tick();
        dis_ena = 1'b0;
    endtask

    task automatic pop();
        ret_ena = 1'b1;
        tick();
        ret_ena = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_ready"}, 32'(dis_ready), 32'd1);
        chk({tag, "_match"}, {28'd0, match_ql, match_rs1, match_rs2, match_rd}, 32'd0);
        chk({tag, "_retq"}, {19'd0, ret_ql, ret_rdwen}, 32'd0);
        chk({tag, "_reti"}, 32'(ret_rdidx), 32'd0);
    endtask

    logic [11:0] model_q [$];
    moitf_entry_t ent;

    initial begin
        vecs[0] = '{12'h002, 1, 0, 0, 5'd5, 5'd5, 5'd0, 4'b1100};
        vecs[1] = '{12'h004, 1, 0, 0, 5'd6, 5'd0, 5'd0, 4'b0000};
        vecs[2] = '{12'h010, 0, 1, 0, 5'd0, 5'd5, 5'd0, 4'b1010};
        vecs[3] = '{12'h100, 0, 0, 1, 5'd0, 5'd0, 5'd7, 4'b0000};
        vecs[4] = '{12'h000, 0, 0, 1, 5'd5, 5'd0, 5'd5, 4'b0001};
        vecs[5] = '{12'hFFF, 1, 1, 1, 5'd0, 5'd0, 5'd0, 4'b1000};

        // Reset state with all-ones hazard candidate.
        chk_ql = 12'hFFF; chk_rs1en = 1; chk_rs2en = 1; chk_rdwen = 1;
        chk_rs1idx = 5'd5; chk_rs2idx = 5'd5; chk_rdidx = 5'd5;
        #2;
        chk_idle("reset");
        chk("reset_err", 32'(ret_err), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Entry allocated this cycle must not match yet.
        ent = '{ql: 12'h003, rdwen: 1'b1, rdidx: 5'd5};
        dis_ena = 1; dis_ql = ent.ql; dis_rdwen = ent.rdwen; dis_rdidx = ent.rdidx;
        chk_ql = 12'h002; chk_rs1en = 1; chk_rs1idx = 5'd5; chk_rs2en = 0; chk_rdwen = 0;
        #1;
        chk("same_cycle_ql", 32'(match_ql), 32'd0);
        chk("same_cycle_rs1", 32'(match_rs1), 32'd0);
        tick();
        dis_ena = 0;
        chk("alloc1_count", 32'(count), 32'd1);
        chk("alloc1_empty", 32'(empty), 32'd0);
        push(12'h030, 1'b0, 5'd7);

        for (int i = 0; i < 6; i++) begin
            chk_ql = vecs[i].ql;
            chk_rs1en = vecs[i].rs1en; chk_rs2en = vecs[i].rs2en; chk_rdwen = vecs[i].rden;
            chk_rs1idx = vecs[i].rs1; chk_rs2idx = vecs[i].rs2; chk_rdidx = vecs[i].rd;
            #1;
            chk($sformatf("vec%0d_match", i),
                {28'd0, match_ql, match_rs1, match_rs2, match_rd}, 32'(vecs[i].exp));
        end

        chk("head0", {19'd0, ret_ql, ret_rdwen}, {19'd0, 12'h003, 1'b1});
        chk("head0_idx", 32'(ret_rdidx), 32'd5);
        pop();
        chk("head1", {19'd0, ret_ql, ret_rdwen}, {19'd0, 12'h030, 1'b0});
        chk("head1_idx", 32'(ret_rdidx), 32'd7);
        pop();
        chk("drained_empty", 32'(empty), 32'd1);

        // Fill to full, then overflow attempt.
        push(12'h001, 1'b1, 5'd1);
        push(12'h002, 1'b1, 5'd2);
        push(12'h004, 1'b1, 5'd3);
        push(12'h008, 1'b1, 5'd4);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_ready", 32'(dis_ready), 32'd0);
        chk("full_count", 32'(count), 32'd4);
        push(12'h800, 1'b1, 5'd9);
        chk("ovf_count", 32'(count), 32'd4);
        ret_ena = 1; dis_ena = 1; dis_ql = 12'h400;
        #1;
        chk("ovf_head", 32'(ret_ql), 32'h001);
        tick();
        ret_ena = 0; dis_ena = 0;
        chk("ret_full_count", 32'(count), 32'd3);
        chk("ret_full_head", 32'(ret_ql), 32'h002);
        chk("ret_full_ready", 32'(dis_ready), 32'd1);
        pop();
        model_q.push_back(12'h004);
        model_q.push_back(12'h008);

        // Steady-state alloc+retire across pointer wrap.
        for (int k = 0; k < 10; k++) begin
            dis_ena = 1; ret_ena = 1; dis_ql = 12'h010 + 12'(k); dis_rdwen = 0;
            #1;
            chk($sformatf("wrap%0d_head", k), 32'(ret_ql), 32'(model_q[0]));
            tick();
            void'(model_q.pop_front());
            model_q.push_back(12'h010 + 12'(k));
            chk($sformatf("wrap%0d_cnt", k), {29'd0, count}, 32'd2);
            chk($sformatf("wrap%0d_flags", k), {30'd0, full, empty}, 32'd0);
        end
        dis_ena = 0; ret_ena = 0;
        chk("wrap_tail_head", 32'(ret_ql), 32'(model_q[0]));
        pop();
        chk("wrap_last_head", 32'(ret_ql), 32'(model_q[1]));
        pop();
        chk("wrap_drain_empty", 32'(empty), 32'd1);

        // Retire on empty with simultaneous allocate.
        ret_ena = 1; dis_ena = 1; dis_ql = 12'h020; dis_rdwen = 1; dis_rdidx = 5'd3;
        tick();
        ret_ena = 0; dis_ena = 0;
        chk("underflow_err", 32'(ret_err), 32'd1);
        chk("underflow_count", 32'(count), 32'd1);
        push(12'h040, 1'b1, 5'd4);
        push(12'h080, 1'b1, 5'd6);
        chk("pre_flush_count", 32'(count), 32'd3);
        chk("err_sticky", 32'(ret_err), 32'd1);

        // Flush wins over a same-cycle allocate.
        flush = 1; dis_ena = 1; dis_ql = 12'hFFF; dis_rdwen = 1; dis_rdidx = 5'd5;
        tick();
        flush = 0; dis_ena = 0;
        chk_ql = 12'hFFF; chk_rs1en = 1; chk_rs2en = 1; chk_rdwen = 1;
        chk_rs1idx = 5'd3; chk_rs2idx = 5'd4; chk_rdidx = 5'd5;
        #1;
        chk_idle("flush");
        chk("flush_err", 32'(ret_err), 32'd1);

        // Asynchronous reset mid-operation.
        push(12'h003, 1'b1, 5'd3);
        push(12'h00C, 1'b1, 5'd4);
        chk("prereset_count", 32'(count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("async");
        chk("async_err", 32'(ret_err), 32'd0);
        tick();
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
